// File: rtl/jtag_bridge_pkg.sv
// jtag_bridge_pkg
// Shared types and constants for the JTAG stream bridge: the bus-sequencing
// state enum, the jtag_uart register map and field positions, and the
// credit clamp used when loading WSPACE into the 8-bit credit counter.
package jtag_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RD_CTRL = 2'd2,
        WR      = 2'd3
    } state_e;

    localparam logic ADDR_DATA  = 1'b0;
    localparam logic ADDR_CTRL  = 1'b1;
    localparam int   RVALID_BIT = 15;
    localparam int   WSPACE_LSB = 16;
    localparam int   WSPACE_MSB = 31;

    // The credit counter is 8 bits wide; larger WSPACE values saturate.
    function automatic logic [7:0] clamp_credits(input logic [15:0] wspace);
        return (wspace > 16'd255) ? 8'hFF : wspace[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with extra-MSB pointers so full/empty and the level
// fall out of pointer arithmetic.  A push and a pop in the same cycle are
// both honoured even when full (the slot being read is the one refilled)
// or empty (the pushed word passes straight through to data_o).
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    write request and word
//   pop_i, data_o     read request and head word
//   full_o, empty_o   status flags
//   level_o           number of stored words (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // On empty, a simultaneous push/pop is a pure pass-through: nothing stored.
    assign do_push = push_i && (!full_o || pop_i) && !(empty_o && pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? data_i : mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/jtag_stream_bridge.sv
// jtag_stream_bridge
// Bridges multi-byte valid/ready streams to the jtag_uart Avalon-MM slave.
// TX words are queued and written LSB byte first, only against credits read
// from the control register's WSPACE field, so no write is ever dropped.
// RX bytes are polled from the data register and assembled LSB first into
// words; the data register is never read while the RX FIFO is full.
// Ports:
//   Clk, Reset                       clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready        user TX word stream
//   rx_data/rx_valid/rx_ready        user RX word stream
//   tx_level, rx_level               FIFO occupancy in words
//   av_*                             Avalon-MM master to the jtag_uart
//
// state   | meaning
// IDLE    | choose the next bus turn (round-robin RX/TX)
// RD_DATA | reading the data register, up to RX_BURST times per turn
// RD_CTRL | reading the control register to load write credits
// WR      | writing TX bytes while credits and words remain
module jtag_stream_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int RX_BURST   = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [8*DATA_BYTES-1:0]    tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [8*DATA_BYTES-1:0]    rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(TX_DEPTH):0]  tx_level,
    output logic [$clog2(RX_DEPTH):0]  rx_level,
    output logic                       av_address,
    output logic                       av_read_n,
    output logic                       av_write_n,
    output logic [31:0]                av_writedata,
    input  logic [31:0]                av_readdata,
    input  logic                       av_waitrequest
);
    localparam int W    = 8 * DATA_BYTES;
    localparam int IW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int BW   = $clog2(RX_BURST + 1);
    localparam int TXLW = $clog2(TX_DEPTH) + 1;
    localparam int RXLW = $clog2(RX_DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_BYTES - 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(RX_BURST - 1);

    state_e         state_q, state_d;
    logic           turn_q, turn_d;          // 0: RX has priority, 1: TX
    logic [IW-1:0]  rx_k_q, rx_k_d;
    logic [W-1:0]   rx_word_q, rx_word_d;
    logic [IW-1:0]  tx_j_q, tx_j_d;
    logic [7:0]     credits_q, credits_d;
    logic [BW-1:0]  burst_q, burst_d;

    logic           tx_push, tx_pop, tx_full, tx_empty;
    logic [W-1:0]   tx_head;
    logic           rx_push, rx_pop, rx_full, rx_empty;
    logic [W-1:0]   rx_word_ins;
    logic           rx_space_after, tx_empty_after;
    logic [7:0]     tx_byte;
    logic           unused_rd;

    assign unused_rd = ^av_readdata[RVALID_BIT-1:8];

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    sync_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (tx_push),
        .data_i  (tx_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (rx_push),
        .data_i  (rx_word_ins),
        .pop_i   (rx_pop),
        .data_o  (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        rx_k_d       = rx_k_q;
        rx_word_d    = rx_word_q;
        tx_j_d       = tx_j_q;
        credits_d    = credits_q;
        burst_d      = burst_q;
        rx_push      = 1'b0;
        tx_pop       = 1'b0;
        av_address   = ADDR_DATA;
        av_read_n    = 1'b1;
        av_write_n   = 1'b1;
        av_writedata = 32'h0;
        tx_byte      = tx_head[{tx_j_q, 3'b000} +: 8];
        rx_word_ins  = rx_word_q;
        rx_word_ins[{rx_k_q, 3'b000} +: 8] = av_readdata[7:0];
        // A pop racing this push is ignored, so a burst may stop one word early.
        rx_space_after = !rx_push || (rx_level < RXLW'(RX_DEPTH - 1));
        tx_empty_after = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_full && (!turn_q || tx_empty)) begin
                    state_d = RD_DATA;
                    burst_d = '0;
                    turn_d  = 1'b1;
                end else if (!tx_empty) begin
                    state_d = RD_CTRL;
                    turn_d  = 1'b0;
                end
            end
            RD_DATA: begin
                av_read_n = 1'b0;
                if (!av_waitrequest) begin
                    if (av_readdata[RVALID_BIT]) begin
                        if (rx_k_q == LAST_IDX) begin
                            rx_push   = 1'b1;
                            rx_k_d    = '0;
                            rx_word_d = '0;
                        end else begin
                            rx_k_d    = rx_k_q + 1'b1;
                            rx_word_d = rx_word_ins;
                        end
                        rx_space_after = !rx_push || (rx_level < RXLW'(RX_DEPTH - 1));
                        if (rx_space_after && (burst_q != LAST_BURST)) begin
                            burst_d = burst_q + 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD_CTRL: begin
                av_read_n  = 1'b0;
                av_address = ADDR_CTRL;
                if (!av_waitrequest) begin
                    credits_d = clamp_credits(av_readdata[WSPACE_MSB:WSPACE_LSB]);
                    state_d   = (credits_d != 8'd0) ? WR : IDLE;
                end
            end
            WR: begin
                av_write_n   = 1'b0;
                av_writedata = {24'h0, tx_byte};
                if (!av_waitrequest) begin
                    credits_d = credits_q - 1'b1;
                    if (tx_j_q == LAST_IDX) begin
                        tx_pop = 1'b1;
                        tx_j_d = '0;
                    end else begin
                        tx_j_d = tx_j_q + 1'b1;
                    end
                    tx_empty_after = tx_pop && !tx_push && (tx_level == TXLW'(1));
                    if ((credits_q == 8'd1) || tx_empty_after) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            turn_q    <= 1'b0;
            rx_k_q    <= '0;
            rx_word_q <= '0;
            tx_j_q    <= '0;
            credits_q <= '0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            rx_k_q    <= rx_k_d;
            rx_word_q <= rx_word_d;
            tx_j_q    <= tx_j_d;
            credits_q <= credits_d;
            burst_q   <= burst_d;
        end
    end

endmodule
